// File: rtl/jpeg_enc_pkg.sv
// Shared JPEG encoder definitions: block geometry, zigzag scan FSM states and
// the default coefficient type.
package jpeg_enc_pkg;

  localparam int BLK_COEFS = 64;
  localparam int IDX_W     = 6;
  localparam int ZZ_COEF_W = 8;

  typedef logic [ZZ_COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } zz_state_t;

endpackage

// File: rtl/zz_last_nz.sv
// 64-input priority encoder: zigzag index of the highest nonzero coefficient.
// Only built when ZIGZAG_SCAN_EOB_EN is defined.
`ifdef ZIGZAG_SCAN_EOB_EN
module zz_last_nz
  import jpeg_enc_pkg::*;
#(
  parameter int COEF_W = 8
) (
  input  logic [BLK_COEFS*COEF_W-1:0] coefs,
  output logic [IDX_W-1:0]            last_idx
);

  // Later indices overwrite earlier ones; an all-zero block yields index 0.
  always_comb begin
    last_idx = '0;
    for (int k = 0; k < BLK_COEFS; k++) begin
      if (coefs[COEF_W*k +: COEF_W] != '0) last_idx = IDX_W'(k);
    end
  end

endmodule
`endif

// File: rtl/zigzag_scan_ctrl.sv
// Sequences one raster block through the external zigzag_reorder pipeline and
// streams the result one coefficient per beat. ZIGZAG_SCAN_EOB_EN trims trailing zeros.
module zigzag_scan_ctrl
  import jpeg_enc_pkg::*;
#(
  parameter int COEF_W = 8,
  parameter int ZZ_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BLK_COEFS*COEF_W-1:0] in_block,
  output logic [BLK_COEFS*COEF_W-1:0] zz_matrix,
  input  logic [BLK_COEFS*COEF_W-1:0] zz_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [COEF_W-1:0]           out_coef,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        out_last,
  output logic                        busy
);

  localparam int BLK_W = BLK_COEFS * COEF_W;
  localparam int CNT_W = $clog2(ZZ_LAT + 1) + 1;

  zz_state_t        state_q, state_d;
  logic [BLK_W-1:0] hold_q, buf_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q, last_idx;
  logic             accept, capture, beat, at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    capture   = 1'b0;
    beat      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready) begin
          beat = 1'b1;
          if (at_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // cnt_q counts pipeline cycles still outstanding; zz_out is sampled one edge after it hits 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      buf_q  <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
    end else begin
      if (accept) begin
        hold_q <= in_block;
        cnt_q  <= CNT_W'(ZZ_LAT);
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (capture) begin
        buf_q <= zz_out;
        idx_q <= '0;
      end else if (beat && !at_last) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

`ifdef ZIGZAG_SCAN_EOB_EN
  logic [IDX_W-1:0] last_nz;
  logic [IDX_W-1:0] last_idx_q;

  zz_last_nz #(.COEF_W(COEF_W)) u_last_nz (
    .coefs    (zz_out),
    .last_idx (last_nz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_idx_q <= '0;
    else if (capture) last_idx_q <= last_nz;
  end

  assign last_idx = last_idx_q;
`else
  assign last_idx = IDX_W'(BLK_COEFS - 1);
`endif

  // Beat fields are gated so nothing stale is visible outside STREAM.
  assign at_last   = (idx_q == last_idx);
  assign zz_matrix = hold_q;
  assign out_coef  = out_valid ? buf_q[COEF_W*idx_q +: COEF_W] : '0;
  assign out_idx   = out_valid ? idx_q : '0;
  assign out_last  = out_valid && at_last;

endmodule

// File: tb/tb_zigzag_scan_ctrl.sv
// Self-checking bench for zigzag_scan_ctrl: models the external 2-stage zigzag_reorder
// and predicts the beat stream from diagonal-walk zigzag ordering.
module tb_zigzag_scan_ctrl;
  import jpeg_enc_pkg::*;

  typedef logic [BLK_COEFS*ZZ_COEF_W-1:0] blk_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  blk_t             in_block;
  blk_t             zz_matrix;
  blk_t             zz_out;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_coef;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             busy;

  int passed = 0;
  int total  = 0;

  zigzag_scan_ctrl #(.COEF_W(8), .ZZ_LAT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .zz_matrix (zz_matrix),
    .zz_out    (zz_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raster position of zigzag index k, by walking anti-diagonals s = r + c.
  function automatic int zz_raster(input int k);
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      for (int j = 0; j <= hi - lo; j++) begin
        int r = (s % 2 == 0) ? hi - j : lo + j;
        if (n == k) return 8 * r + (s - r);
        n++;
      end
    end
    return 0;
  endfunction

  function automatic blk_t zz_reorder(input blk_t m);
    blk_t o;
    for (int k = 0; k < BLK_COEFS; k++) o[8*k +: 8] = m[8*zz_raster(k) +: 8];
    return o;
  endfunction

  function automatic coef_t expCoef(input blk_t b, input int k);
    return b[8*zz_raster(k) +: 8];
  endfunction

  function automatic int expLast(input blk_t b);
    int last = BLK_COEFS - 1;
`ifdef ZIGZAG_SCAN_EOB_EN
    last = 0;
    for (int k = 0; k < BLK_COEFS; k++) if (expCoef(b, k) != 0) last = k;
`endif
    return last;
  endfunction

  function automatic blk_t randBlock(input int density);
    blk_t b;
    for (int n = 0; n < BLK_COEFS; n++)
      b[8*n +: 8] = ($urandom_range(0, 99) < density) ? 8'($urandom_range(1, 255)) : 8'd0;
    return b;
  endfunction

  // Behavioural stand-in for the parent's 2-stage zigzag_reorder pipeline.
  blk_t zz_s0, zz_s1;
  always @(posedge clk) begin
    zz_s0 <= zz_reorder(zz_matrix);
    zz_s1 <= zz_s0;
  end
  assign zz_out = zz_s1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic timeoutFail(input string tag);
    total++;
    $error("[TB] FAIL %s: timed out waiting on DUT", tag);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_in_ready"},  in_ready,   1);
    checkOutput({tag, "_out_valid"}, out_valid,  0);
    checkOutput({tag, "_out_last"},  out_last,   0);
    checkOutput({tag, "_out_coef"},  out_coef,   0);
    checkOutput({tag, "_out_idx"},   out_idx,    0);
    checkOutput({tag, "_busy"},      busy,       0);
    checkOutput({tag, "_zz_matrix"}, |zz_matrix, 0);
  endtask

  task automatic applyStimulus(input blk_t blk, input bit hold_valid, input blk_t next_blk);
    int guard = 0;
    in_block = blk;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    if (in_ready !== 1'b1) begin
      timeoutFail("accept");
      in_valid = 1'b0;
      return;
    end
    step();
    checkOutput("zz_matrix_loaded", zz_matrix === blk, 1);
    if (hold_valid) in_block = next_blk;
    else            in_valid = 1'b0;
  endtask

  // Consumes one block's beats with out_ready high pct% of cycles; stop_at >= 0 aborts there.
  task automatic collectBlock(input blk_t blk, input int pct, input int stop_at);
    int lat = 0;
    int k = 0;
    int guard = 0;
    int last_k;
    bit done = 1'b0;
    bit rdy;
    last_k = expLast(blk);
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    checkOutput("first_beat_latency", lat, 3);
    checkOutput("zz_matrix_hold", zz_matrix === blk, 1);
    while (!done && guard < 4000) begin
      if (k == stop_at) return;
      checkOutput("stream_in_ready", in_ready, 0);
      checkOutput("stream_busy", busy, 1);
      checkOutput("stream_out_valid", out_valid, 1);
      checkOutput($sformatf("coef[%0d]", k), out_coef, expCoef(blk, k));
      checkOutput($sformatf("idx[%0d]", k), out_idx, k);
      checkOutput($sformatf("last[%0d]", k), out_last, (k == last_k));
      rdy = ($urandom_range(0, 99) < pct);
      out_ready = rdy;
      step();
      guard++;
      if (rdy) begin
        if (k == last_k) done = 1'b1;
        k++;
      end
    end
    if (!done) timeoutFail("stream");
    checkOutput("beat_count", k, last_k + 1);
    checkOutput("idle_in_ready", in_ready, 1);
    checkOutput("idle_out_valid", out_valid, 0);
    checkOutput("idle_busy", busy, 0);
  endtask

  blk_t ramp, blk_a, blk_b, sparse, zero_blk;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_block  = '0;
    out_ready = 1'b0;
    for (int n = 0; n < BLK_COEFS; n++) ramp[8*n +: 8] = 8'(n);
    sparse = '0;
    sparse[8*0 +: 8] = 8'd5;
    sparse[8*9 +: 8] = 8'd3;
    zero_blk = '0;

    repeat (3) step();
    checkReset("in_reset");
    rst_n = 1'b1;
    step();
    checkReset("after_release");

    $display("[TB] ramp block, out_ready always high");
    applyStimulus(ramp, 1'b0, '0);
    collectBlock(ramp, 100, -1);

    $display("[TB] ramp block, out_ready 50%%");
    applyStimulus(ramp, 1'b0, '0);
    collectBlock(ramp, 50, -1);

    $display("[TB] back-to-back blocks with in_valid held");
    blk_a = randBlock(100);
    blk_b = randBlock(100);
    applyStimulus(blk_a, 1'b1, blk_b);
    collectBlock(blk_a, 100, -1);
    applyStimulus(blk_b, 1'b0, '0);
    collectBlock(blk_b, 60, -1);

    $display("[TB] reset at idx 20");
    applyStimulus(ramp, 1'b0, '0);
    collectBlock(ramp, 100, 20);
    #2 rst_n = 1'b0;
    #1 checkReset("mid_reset");
    step();
    checkReset("mid_reset_held");
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      step();
      checkOutput("post_reset_quiet", out_valid, 0);
    end
    blk_a = randBlock(100);
    applyStimulus(blk_a, 1'b0, '0);
    collectBlock(blk_a, 80, -1);

    $display("[TB] sparse and all-zero blocks");
    applyStimulus(sparse, 1'b0, '0);
    collectBlock(sparse, 100, -1);
    applyStimulus(zero_blk, 1'b0, '0);
    collectBlock(zero_blk, 70, -1);

    $display("[TB] random sparse blocks");
    for (int i = 0; i < 3; i++) begin
      blk_a = randBlock(5);
      applyStimulus(blk_a, 1'b0, '0);
      collectBlock(blk_a, 70, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
